// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_word_packer
// Brief    : Pops bytes from a registered-read byte FIFO and packs them
//            little-endian into words on a valid/ready output.
//            Optional partial-word flush: FIFO_PACKER_FLUSH_EN.
// Revision : 1.0
// ============================================================================
module fifo_word_packer #(
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT        = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fifo_empty,
    input  logic [7:0]                  fifo_data,
    output logic                        ren,
    output logic [8*BYTES_PER_WORD-1:0] word_data,
    output logic [BYTES_PER_WORD-1:0]   word_keep,
    output logic                        word_valid,
    input  logic                        word_ready
);

    localparam int                c_CNT_W = $clog2(BYTES_PER_WORD) + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(BYTES_PER_WORD);

    if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("fifo_word_packer: parameter out of range");
    end

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [c_CNT_W-1:0]          r_count;
    logic [c_CNT_W-1:0]          w_count_nxt;
    logic                        r_pending;
    logic [8*BYTES_PER_WORD-1:0] r_word;
    logic [8*BYTES_PER_WORD-1:0] w_word_nxt;
    logic                        w_idle_hit;

`ifdef FIFO_PACKER_FLUSH_EN
    logic [7:0] r_idle;
    logic [7:0] w_idle_nxt;

    // Idle time only accrues while a partial word waits on an empty FIFO
    // with nothing in flight.
    always_comb begin
        w_idle_nxt = r_idle;
        w_idle_hit = 1'b0;
        if (r_state != S_FILL || r_pending) begin
            w_idle_nxt = '0;
        end else if (r_count != '0 && fifo_empty) begin
            w_idle_nxt = r_idle + 8'd1;
            if (w_idle_nxt == 8'(TIMEOUT)) begin
                w_idle_hit = 1'b1;
                w_idle_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle <= '0;
        end else begin
            r_idle <= w_idle_nxt;
        end
    end

    always_comb begin
        word_keep = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            word_keep[i] = (r_count > c_CNT_W'(i));
        end
    end
`else
    assign w_idle_hit = 1'b0;
    assign word_keep  = {BYTES_PER_WORD{r_state == S_HOLD}};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_word_nxt  = r_word;
        word_valid  = (r_state == S_HOLD);
        // The in-flight read is counted so ren never over-reads past one word.
        ren         = (r_state == S_FILL) && !fifo_empty &&
                      ((r_count + c_CNT_W'(r_pending)) < c_FULL);
        case (r_state)
            S_FILL: begin
                if (r_pending) begin
                    for (int i = 0; i < BYTES_PER_WORD; i++) begin
                        if (r_count == c_CNT_W'(i)) begin
                            w_word_nxt[8*i +: 8] = fifo_data;
                        end
                    end
                    w_count_nxt = r_count + c_CNT_W'(1);
                    if (w_count_nxt == c_FULL) begin
                        w_state_nxt = S_HOLD;
                    end
                end else if (w_idle_hit) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (word_ready) begin
                    w_state_nxt = S_FILL;
                    w_count_nxt = '0;
                    w_word_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FILL;
            r_count   <= '0;
            r_pending <= 1'b0;
            r_word    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_pending <= ren;
            r_word    <= w_word_nxt;
        end
    end

    assign word_data = r_word;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_word_packer
// Brief    : Bench for fifo_word_packer with a behavioural byte FIFO and a
//            byte-queue word reference.
// Revision : 1.0
// ============================================================================
module tb_fifo_word_packer;

    localparam int BPW = 4;
    localparam int TO  = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        ren;
    logic [31:0] word_data;
    logic [3:0]  word_keep;
    logic        word_valid;
    logic        word_ready;

    logic        push_en;
    logic [7:0]  push_data;
    logic        rand_ready;
    logic        stats_clr;

    always #5 clk = ~clk;

    fifo_word_packer #(.BYTES_PER_WORD(BPW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .ren        (ren),
        .word_data  (word_data),
        .word_keep  (word_keep),
        .word_valid (word_valid),
        .word_ready (word_ready)
    );

    // 16-entry byte FIFO with one-cycle registered read.
    logic [7:0] mem [16];
    logic [3:0] wp, rp;
    int         fcnt;
    always @(posedge clk) begin
        if (rst) begin
            wp <= '0; rp <= '0; fcnt <= 0; fifo_data <= '0;
        end else begin
            if (ren && fcnt != 0) begin
                fifo_data <= mem[rp];
                rp <= rp + 4'd1;
            end
            if (push_en && fcnt < 16) begin
                mem[wp] <= push_data;
                wp <= wp + 4'd1;
            end
            fcnt <= fcnt + ((push_en && fcnt < 16) ? 1 : 0) - ((ren && fcnt != 0) ? 1 : 0);
        end
    end
    assign fifo_empty = (fcnt == 0);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: every pushed byte in order; each accepted word takes the next bytes.
    logic [7:0] q[$];

    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          ren_cycles, ren_runs, first_ren, valid_rise, words_seen, ren_since_word;
    logic        prev_ren, prev_hold;
    logic [31:0] hold_data, last_word, sb_w;
    logic [3:0]  hold_keep, last_keep, sb_k;
    int          sb_n;

    always @(negedge clk) begin
        if (rst || stats_clr) begin
            ren_cycles = 0; ren_runs = 0; first_ren = -1; valid_rise = -1;
            words_seen = 0; ren_since_word = 0; prev_ren = 1'b0; prev_hold = 1'b0;
        end else begin
            if (ren) begin
                check_eq("ren_while_empty", 64'(fifo_empty), 64'(0));
                if (!prev_ren) ren_runs++;
                if (first_ren < 0) first_ren = cyc;
                ren_cycles++;
                ren_since_word++;
                check_eq("ren_overread", 64'(ren_since_word <= BPW), 64'(1));
            end
            prev_ren = ren;
            if (word_valid) begin
                check_eq("ren_in_hold", 64'(ren), 64'(0));
                if (valid_rise < 0) valid_rise = cyc;
                if (prev_hold) begin
                    check_eq("hold_data_stable", 64'(word_data), 64'(hold_data));
                    check_eq("hold_keep_stable", 64'(word_keep), 64'(hold_keep));
                end
                if (word_ready) begin
                    sb_n = (q.size() < BPW) ? q.size() : BPW;
                    sb_w = '0;
                    for (int i = 0; i < sb_n; i++) sb_w = sb_w | (32'(q.pop_front()) << (8 * i));
`ifdef FIFO_PACKER_FLUSH_EN
                    sb_k = 4'((1 << sb_n) - 1);
`else
                    sb_k = 4'hF;
`endif
                    check_eq("word_data", 64'(word_data), 64'(sb_w));
                    check_eq("word_keep", 64'(word_keep), 64'(sb_k));
                    last_word = word_data;
                    last_keep = word_keep;
                    words_seen++;
                    ren_since_word = 0;
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = 1'b1;
                    hold_data = word_data;
                    hold_keep = word_keep;
                end
            end else begin
                if (prev_hold) check_eq("valid_dropped", 64'(word_valid), 64'(1));
                prev_hold = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) word_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_stats();
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int guard = 0;
        while (fcnt >= 16 && guard < 300) begin
            step();
            guard++;
        end
        if (guard >= 300) check_eq("fifo_full_wait", 64'(fcnt < 16), 64'(1));
        push_en   = 1'b1;
        push_data = b;
        q.push_back(b);
        step();
        push_en   = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int k = 0;
        while (words_seen < n && k < budget) begin
            step();
            k++;
        end
        check_eq(tag, 64'(words_seen >= n), 64'(1));
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int k = 0;
        while (!word_valid && k < budget) begin
            step();
            k++;
        end
        check_eq(tag, 64'(word_valid), 64'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        repeat (2) step();
        rst = 1'b0;
    endtask

    logic [7:0]  b8 [8];
    logic [31:0] exp1, exp2;

    initial begin
        rst = 1'b1; push_en = 1'b0; push_data = '0; word_ready = 1'b0;
        rand_ready = 1'b0; stats_clr = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Idle after reset with an empty FIFO.
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq("rst_ren", 64'(ren), 64'(0));
            check_eq("rst_valid", 64'(word_valid), 64'(0));
            check_eq("rst_keep", 64'(word_keep), 64'(0));
            check_eq("rst_data", 64'(word_data), 64'(0));
        end

        // Single word, latency and ren pattern.
        word_ready = 1'b1;
        clear_stats();
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        wait_words(1, 50, "w1_timeout");
        repeat (3) step();
        check_eq("w1_ren_cycles", 64'(ren_cycles), 64'(4));
        check_eq("w1_ren_runs", 64'(ren_runs), 64'(1));
        check_eq("w1_latency", 64'(valid_rise - first_ren), 64'(BPW + 1));
        check_eq("w1_data", 64'(last_word), 64'(32'h44332211));
        check_eq("w1_keep", 64'(last_keep), 64'(4'hF));

        // Backpressure: two words queued, ready held low.
        word_ready = 1'b0;
        clear_stats();
        for (int i = 0; i < 8; i++) b8[i] = 8'($urandom);
        exp1 = {b8[3], b8[2], b8[1], b8[0]};
        exp2 = {b8[7], b8[6], b8[5], b8[4]};
        for (int i = 0; i < 8; i++) push_byte(b8[i]);
        wait_valid(50, "bp_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("bp_valid", 64'(word_valid), 64'(1));
            check_eq("bp_ren", 64'(ren), 64'(0));
            check_eq("bp_data", 64'(word_data), 64'(exp1));
        end
        word_ready = 1'b1;
        wait_words(2, 50, "bp_w2_timeout");
        check_eq("bp_w2_data", 64'(last_word), 64'(exp2));

        // Gap in the byte stream mid-word.
        clear_stats();
        push_byte(8'hAA); push_byte(8'hBB);
        repeat (5) step();
        push_byte(8'hCC); push_byte(8'hDD);
        wait_words(1, 50, "gap_timeout");
        repeat (5) step();
        check_eq("gap_words", 64'(words_seen), 64'(1));
        check_eq("gap_data", 64'(last_word), 64'(32'hDDCCBBAA));

        // Lone byte: flushed after the timeout, or held forever.
        word_ready = 1'b0;
        clear_stats();
        push_byte(8'hAA);
`ifdef FIFO_PACKER_FLUSH_EN
        wait_valid(60, "flush_timeout");
        check_eq("flush_latency", 64'(valid_rise - first_ren), 64'(TO + 2));
        check_eq("flush_data", 64'(word_data), 64'(32'h000000AA));
        check_eq("flush_keep", 64'(word_keep), 64'(4'h1));
        word_ready = 1'b1;
        wait_words(1, 10, "flush_accept");
`else
        repeat (100) step();
        check_eq("noflush_no_valid", 64'(valid_rise < 0), 64'(1));
        check_eq("noflush_ren_cycles", 64'(ren_cycles), 64'(1));
`endif

        // Reset with two bytes captured and a third in flight.
        do_reset();
        word_ready = 1'b1;
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
        step();
        rst = 1'b1;
        q.delete();
        step();
        rst = 1'b0;
        clear_stats();
        push_byte(8'h5A); push_byte(8'h6B); push_byte(8'h7C); push_byte(8'h8D);
        wait_words(1, 50, "mrst_timeout");
        check_eq("mrst_data", 64'(last_word), 64'(32'h8D7C6B5A));

        // Random traffic with random backpressure.
        clear_stats();
        rand_ready = 1'b1;
        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) step();
            push_byte(8'($urandom));
        end
        rand_ready = 1'b0;
        word_ready = 1'b1;
        for (int k = 0; k < 400 && q.size() != 0; k++) step();
        repeat (3) step();
        check_eq("rand_drain", 64'(q.size()), 64'(0));
        check_eq("rand_words", 64'(words_seen), 64'(40));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_word_packer.md
# fifo_word_packer

Downstream consumer of the 16-entry byte FIFO. Pops bytes through the FIFO's `ren`/`is_empty`/`out` interface, accounting for the FIFO's one-cycle registered read latency. Packs `BYTES_PER_WORD` consecutive bytes little-endian into one word and presents that word on a valid/ready handshake to the next stage. Never issues a read to an empty FIFO, because the FIFO has no underflow protection.

## Interface
Parameters:
- `BYTES_PER_WORD`, 4: bytes per output word; legal range 2..8.
- `TIMEOUT`, 15: idle cycles before a partial word is flushed; used only with the flush feature; legal range 1..255.

Ports:
- `clk`  in  1: sole clock; all logic on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `fifo_empty`  in  1: FIFO `is_empty`.
- `fifo_data`  in  8: FIFO `out`; valid in the cycle after `ren` was high.
- `ren`  out  1: FIFO read enable; combinational from registered state and `fifo_empty`.
- `word_data`  out  8*BYTES_PER_WORD: packed word; byte i at bits [8i+7:8i].
- `word_keep`  out  BYTES_PER_WORD: byte-valid mask for `word_data`.
- `word_valid`  out  1: word available.
- `word_ready`  in  1: downstream accepts the word.

## Operation
- Registered state:
  - `state`: FILL or HOLD.
  - `count`: bytes captured into the current word, 0..BYTES_PER_WORD.
  - `pending`: a read was issued last cycle.
  - Word shift register.
  - Idle counter (flush feature only).
- `ren = (state==FILL) & ~fifo_empty & ((count + pending) < BYTES_PER_WORD)`.
  - Compare at width ≥ $clog2(BYTES_PER_WORD)+1 so the sum cannot wrap.
- Capture:
  - When `pending` is 1, `fifo_data` is written to byte lane `count` and `count` increments.
  - `pending` <= `ren` every cycle.
- FILL → HOLD: on the capture that makes `count == BYTES_PER_WORD`. `word_keep` is then all ones.
- In HOLD:
  - `word_valid = 1` and `ren = 0`.
  - `word_data` and `word_keep` are held stable until the handshake.
- HOLD → FILL: on the cycle with `word_valid & word_ready`.
  - `count` clears to 0.
  - The word register clears to 0.
- `word_ready` is ignored in FILL. `word_valid` never depends combinationally on `word_ready`.
- Reset values:
  - State FILL; `count` 0; `pending` 0; idle counter 0.
  - `word_data` 0; `word_keep` 0; `word_valid` 0; `ren` reflects `fifo_empty` in the first post-reset cycle.
- Reset mid-operation (including with `pending` = 1 or in HOLD): partial and held words are discarded. The in-flight byte is not captured. `rst` is shared with the FIFO, so its pointers reset in the same cycle.
- FIFO goes empty mid-word: `ren` drops, `count` holds, and capture resumes when data returns. There are no bubbles or duplicates in the byte sequence.

## Timing
- Read latency: `ren` high in cycle t → byte captured on the edge ending t+1.
- Word latency: with a non-empty FIFO and FILL at count 0:
  - `ren` is high in cycles t..t+BYTES_PER_WORD-1.
  - `word_valid` rises in cycle t+BYTES_PER_WORD+1.
- Throughput: one byte per cycle while filling. Minimum one idle cycle between words (the handshake cycle, followed by the next `ren`), so 4 bytes per 6 cycles at default.
- `ren` is high at most BYTES_PER_WORD cycles per word; the block never over-reads into the next word.

## Configuration
- Macro: `FIFO_PACKER_FLUSH_EN`.
- Defined:
  - An idle counter increments each cycle with `state==FILL & count>0 & ~pending & fifo_empty`.
  - It clears on any capture and on leaving FILL.
  - On reaching `TIMEOUT`, the block enters HOLD with the partial word.
  - `word_keep` bit i = (i < count); unfilled lanes are 0.
- Not defined:
  - The idle counter is not built.
  - A partial word waits indefinitely for bytes.
  - `word_keep` is all ones whenever `word_valid` is 1.

## Test plan
- Reset, FIFO empty → `ren`=0, `word_valid`=0, `word_keep`=0, `word_data`=0 for 20 cycles.
- Push 0x11,0x22,0x33,0x44 with `word_ready`=1:
  - `ren` is high exactly 4 consecutive cycles.
  - `word_data`=0x44332211 and `word_valid` appear 5 cycles after the first `ren`.
  - `word_keep`=4'hF.
- Push 8 bytes, hold `word_ready`=0 for 10 cycles:
  - First word is stable with `ren`=0 throughout.
  - After ready, the second word arrives in byte order.
  - The FIFO never sees a read while `is_empty`.
- Push 2 bytes, gap of 5 empty cycles, push 2 more → single word 0xDDCCBBAA; no duplicated or dropped byte.
- With `FIFO_PACKER_FLUSH_EN`, push 0xAA only:
  - After 15 idle cycles, `word_valid`=1, `word_data`=0x000000AA, `word_keep`=4'h1.
  - Without the macro, no `word_valid` in 100 cycles.
- Assert `rst` for one cycle with count=2 and `pending`=1, then push 4 fresh bytes → output word contains only the fresh bytes.
